// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, FSM states and
// the oversampling tick divider calculation used by RX and TX.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } uart_state_e;

    function automatic int calc_div(
        input int clkfreq,
        input int baud,
        input int ovs
    );
        return clkfreq / (baud * ovs);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick divider: one-clk tick every c_div clks while
// enabled; synchronous restart holds the count at zero.
module uart_baud_tick #(
    parameter int c_div = 54
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int c_w = (c_div > 1) ? $clog2(c_div) : 1;

    logic [c_w-1:0] cnt_q, cnt_d;
    logic           wrap;

    assign wrap   = (cnt_q == c_w'(c_div - 1));
    assign tick_o = en_i && !restart_i && wrap;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: majority-vote mid-bit sampling,
// parity/framing/break/overrun reporting, ready/valid word output.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int c_clkfreq    = 100_000_000,
    parameter int c_baudrate   = 115_200,
    parameter int c_oversample = 16,
    parameter int c_databits   = 8,
    parameter int c_parity     = 0,
    parameter int c_stopbits   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_in_i,
    output logic [c_databits-1:0] dout_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  parity_err_o,
    output logic                  frame_err_o,
    output logic                  break_o,
    output logic                  overrun_o,
    output logic                  busy_o
);

    localparam int c_div = calc_div(c_clkfreq, c_baudrate, c_oversample);
    localparam int c_mid = c_oversample / 2;
    localparam int c_scw = $clog2(c_oversample);
    localparam int c_w   = c_databits;

    uart_state_e state_q, state_d;

    logic             rx_meta_q, rx_s_q, rx_prev_q;
    logic [c_scw-1:0] sc_q, sc_d;
    logic [3:0]       bc_q, bc_d;
    logic [c_w-1:0]   shreg_q, shreg_d;
    logic [1:0]       smp_q, smp_d;
    logic             perr_fr_q, perr_fr_d;
    logic             ferr_fr_q, ferr_fr_d;

    logic [c_w-1:0]   dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             brk_q, brk_d;
    logic             ovr_q, ovr_d;

    logic s_tick, sc_wrap, mid_done, bit_val, commit;

    uart_baud_tick #(
        .c_div(c_div)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (busy_o),
        .restart_i(state_q == S_IDLE),
        .tick_o   (s_tick)
    );

    assign busy_o       = (state_q != S_IDLE);
    assign dout_o       = dout_q;
    assign valid_o      = valid_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign break_o      = brk_q;
    assign overrun_o    = ovr_q;

    // sc keeps the start-edge phase, so each bit is voted at M-1..M+1
    assign sc_wrap  = (sc_q == c_scw'(c_oversample - 1));
    assign mid_done = s_tick && (sc_q == c_scw'(c_mid + 1));
    assign bit_val  = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_s_q)
                    | (smp_q[0] & rx_s_q);

    always_comb begin
        state_d   = state_q;
        sc_d      = sc_q;
        bc_d      = bc_q;
        shreg_d   = shreg_q;
        smp_d     = smp_q;
        perr_fr_d = perr_fr_q;
        ferr_fr_d = ferr_fr_q;

        if (s_tick) begin
            sc_d = sc_wrap ? '0 : sc_q + 1'b1;
            if (sc_q == c_scw'(c_mid - 1))
                smp_d[1] = rx_s_q;
            if (sc_q == c_scw'(c_mid))
                smp_d[0] = rx_s_q;
        end

        unique case (state_q)
            S_IDLE: begin
                sc_d = '0;
                if (rx_prev_q && !rx_s_q) begin
                    state_d   = S_START;
                    bc_d      = '0;
                    perr_fr_d = 1'b0;
                    ferr_fr_d = 1'b0;
                end
            end
            S_START: begin
                if (mid_done)
                    state_d = bit_val ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (mid_done) begin
                    shreg_d = {bit_val, shreg_q[c_w-1:1]};
                    if (bc_q == 4'(c_databits - 1)) begin
                        bc_d    = '0;
                        state_d = (c_parity != PAR_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        bc_d = bc_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (mid_done) begin
                    perr_fr_d = (c_parity == PAR_ODD)
                              ? ~(^shreg_q ^ bit_val)
                              :  (^shreg_q ^ bit_val);
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (mid_done) begin
                    if (!bit_val)
                        ferr_fr_d = 1'b1;
                    if (bc_q == 4'(c_stopbits - 1))
                        state_d = S_DONE;
                    else
                        bc_d = bc_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign commit = (state_q == S_DONE) && (!valid_q || ready_i);

    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        if (valid_q && ready_i)
            valid_d = 1'b0;
        if (commit) begin
            valid_d = 1'b1;
            dout_d  = shreg_q;
            perr_d  = perr_fr_q;
            ferr_d  = ferr_fr_q;
        end
        brk_d = (state_q == S_DONE) && (shreg_q == '0) && ferr_fr_q;
        ovr_d = (state_q == S_DONE) && !commit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= S_IDLE;
            sc_q      <= '0;
            bc_q      <= '0;
            shreg_q   <= '0;
            smp_q     <= '0;
            perr_fr_q <= 1'b0;
            ferr_fr_q <= 1'b0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx_in_i;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            state_q   <= state_d;
            sc_q      <= sc_d;
            bc_q      <= bc_d;
            shreg_q   <= shreg_d;
            smp_q     <= smp_d;
            perr_fr_q <= perr_fr_d;
            ferr_fr_q <= ferr_fr_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            brk_q     <= brk_d;
            ovr_q     <= ovr_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 8E1 and 7N2 instances on
// separate lines, 625 kbaud so that c_div is exact (10 clks/sample).
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    localparam int BIT = 1600;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx8 = 1'b1, rxp = 1'b1, rx7 = 1'b1;
    logic rdy8 = 1'b0, rdyp = 1'b0, rdy7 = 1'b1;

    logic [7:0] d8, dp;
    logic [6:0] d7;
    logic v8, pe8, fe8, brk8, ovr8, busy8;
    logic vp, pep, fep, brkp, ovrp, busyp;
    logic v7, pe7, fe7, brk7, ovr7, busy7;

    int errors = 0;
    int checks = 0;
    int brk8_cnt = 0;
    int ovr8_cnt = 0;
    int fe7_cnt = 0;
    logic [6:0] q7[$];

    uart_rx_cfg #(
        .c_baudrate(625_000)
    ) u8 (
        .clk(clk), .rst_n(rst_n), .rx_in_i(rx8), .dout_o(d8),
        .valid_o(v8), .ready_i(rdy8), .parity_err_o(pe8),
        .frame_err_o(fe8), .break_o(brk8), .overrun_o(ovr8),
        .busy_o(busy8)
    );

    uart_rx_cfg #(
        .c_baudrate(625_000), .c_parity(2)
    ) up (
        .clk(clk), .rst_n(rst_n), .rx_in_i(rxp), .dout_o(dp),
        .valid_o(vp), .ready_i(rdyp), .parity_err_o(pep),
        .frame_err_o(fep), .break_o(brkp), .overrun_o(ovrp),
        .busy_o(busyp)
    );

    uart_rx_cfg #(
        .c_baudrate(625_000), .c_databits(7), .c_stopbits(2)
    ) u7 (
        .clk(clk), .rst_n(rst_n), .rx_in_i(rx7), .dout_o(d7),
        .valid_o(v7), .ready_i(rdy7), .parity_err_o(pe7),
        .frame_err_o(fe7), .break_o(brk7), .overrun_o(ovr7),
        .busy_o(busy7)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (brk8) brk8_cnt <= brk8_cnt + 1;
        if (ovr8) ovr8_cnt <= ovr8_cnt + 1;
        if (v7 && rdy7) begin
            q7.push_back(d7);
            if (fe7) fe7_cnt <= fe7_cnt + 1;
        end
    end

    task automatic drive(input int sel, input logic v);
        case (sel)
            0:       rx8 = v;
            1:       rxp = v;
            default: rx7 = v;
        endcase
    endtask

    task automatic send(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            drive(sel, bits[i]);
            #BIT;
        end
    endtask

    task automatic take8();
        @(negedge clk) rdy8 = 1'b1;
        @(negedge clk) rdy8 = 1'b0;
    endtask

    task automatic test_reset();
        #23;
        @(negedge clk);
        checks++; if (v8 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", v8); end
        checks++; if (d8 !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", d8); end
        checks++; if ({pe8, fe8, brk8, ovr8} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {pe8, fe8, brk8, ovr8}); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy8); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_8n1();
        send(0, {6'h3f, 1'b1, 8'hD2, 1'b0}, 10);
        @(negedge clk);
        checks++; if (v8 !== 1'b1) begin errors++; $display("FAIL 8n1_valid: got %b want 1", v8); end
        checks++; if (d8 !== 8'hD2) begin errors++; $display("FAIL 8n1_dout: got %h want d2", d8); end
        checks++; if ({pe8, fe8} !== 2'b00) begin errors++; $display("FAIL 8n1_flags: got %b want 00", {pe8, fe8}); end
        repeat (20) @(negedge clk);
        checks++; if (v8 !== 1'b1) begin errors++; $display("FAIL 8n1_hold: got %b want 1", v8); end
        rdy8 = 1'b1;
        @(negedge clk);
        rdy8 = 1'b0;
        checks++; if (v8 !== 1'b0) begin errors++; $display("FAIL 8n1_accept: got %b want 0", v8); end
    endtask

    task automatic test_glitch();
        int o0;
        o0 = ovr8_cnt;
        rx8 = 1'b0;
        #200;
        checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL glitch_busy: got %b want 1", busy8); end
        #200;
        rx8 = 1'b1;
        #(3 * BIT);
        @(negedge clk);
        checks++; if (v8 !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b want 0", v8); end
        checks++; if ({pe8, fe8} !== 2'b00) begin errors++; $display("FAIL glitch_flags: got %b want 00", {pe8, fe8}); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b want 0", busy8); end
        checks++; if (ovr8_cnt !== o0) begin errors++; $display("FAIL glitch_ovr: got %0d want %0d", ovr8_cnt, o0); end
    endtask

    task automatic test_parity();
        send(1, {5'h1f, 1'b1, 1'b1, 8'hD2, 1'b0}, 11);
        @(negedge clk);
        checks++; if (vp !== 1'b1) begin errors++; $display("FAIL par_bad_valid: got %b want 1", vp); end
        checks++; if (dp !== 8'hD2) begin errors++; $display("FAIL par_bad_dout: got %h want d2", dp); end
        checks++; if ({pep, fep} !== 2'b10) begin errors++; $display("FAIL par_bad_flags: got %b want 10", {pep, fep}); end
        @(negedge clk) rdyp = 1'b1;
        @(negedge clk) rdyp = 1'b0;
        send(1, {5'h1f, 1'b1, 1'b0, 8'hD2, 1'b0}, 11);
        @(negedge clk);
        checks++; if (vp !== 1'b1) begin errors++; $display("FAIL par_ok_valid: got %b want 1", vp); end
        checks++; if (dp !== 8'hD2) begin errors++; $display("FAIL par_ok_dout: got %h want d2", dp); end
        checks++; if ({pep, fep} !== 2'b00) begin errors++; $display("FAIL par_ok_flags: got %b want 00", {pep, fep}); end
        @(negedge clk) rdyp = 1'b1;
        @(negedge clk) rdyp = 1'b0;
    endtask

    task automatic test_break();
        int b0;
        b0 = brk8_cnt;
        rx8 = 1'b0;
        #(12 * BIT);
        rx8 = 1'b1;
        #BIT;
        @(negedge clk);
        checks++; if (v8 !== 1'b1) begin errors++; $display("FAIL brk_valid: got %b want 1", v8); end
        checks++; if (d8 !== 8'h00) begin errors++; $display("FAIL brk_dout: got %h want 00", d8); end
        checks++; if ({pe8, fe8} !== 2'b01) begin errors++; $display("FAIL brk_flags: got %b want 01", {pe8, fe8}); end
        checks++; if (brk8_cnt - b0 !== 1) begin errors++; $display("FAIL brk_pulses: got %0d want 1", brk8_cnt - b0); end
        take8();
        #(2 * BIT);
        @(negedge clk);
        checks++; if ({v8, busy8} !== 2'b00) begin errors++; $display("FAIL brk_after: got %b want 00", {v8, busy8}); end
    endtask

    task automatic test_overrun();
        int o0;
        o0 = ovr8_cnt;
        send(0, {6'h3f, 1'b1, 8'h11, 1'b0}, 10);
        send(0, {6'h3f, 1'b1, 8'h22, 1'b0}, 10);
        @(negedge clk);
        checks++; if (v8 !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", v8); end
        checks++; if (d8 !== 8'h11) begin errors++; $display("FAIL ovr_dout: got %h want 11", d8); end
        checks++; if (ovr8_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d want 1", ovr8_cnt - o0); end
        rdy8 = 1'b1;
        @(negedge clk);
        rdy8 = 1'b0;
        checks++; if (v8 !== 1'b0) begin errors++; $display("FAIL ovr_accept: got %b want 0", v8); end
        #(2 * BIT);
        @(negedge clk);
        checks++; if (v8 !== 1'b0) begin errors++; $display("FAIL ovr_no22: got %b want 0", v8); end
        checks++; if (d8 !== 8'h11) begin errors++; $display("FAIL ovr_keep: got %h want 11", d8); end
    endtask

    task automatic test_reset_abort();
        send(0, {6'h3f, 1'b1, 8'hA5, 1'b0}, 4);
        #(BIT / 2);
        checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b want 1", busy8); end
        rst_n = 1'b0;
        rx8 = 1'b1;
        #100;
        checks++; if ({v8, busy8} !== 2'b00) begin errors++; $display("FAIL abort_inrst: got %b want 00", {v8, busy8}); end
        rst_n = 1'b1;
        #(2 * BIT);
        @(negedge clk);
        checks++; if ({v8, busy8} !== 2'b00) begin errors++; $display("FAIL abort_idle: got %b want 00", {v8, busy8}); end
        send(0, {6'h3f, 1'b1, 8'h3C, 1'b0}, 10);
        @(negedge clk);
        checks++; if (v8 !== 1'b1) begin errors++; $display("FAIL abort_valid: got %b want 1", v8); end
        checks++; if (d8 !== 8'h3C) begin errors++; $display("FAIL abort_dout: got %h want 3c", d8); end
        checks++; if ({pe8, fe8} !== 2'b00) begin errors++; $display("FAIL abort_flags: got %b want 00", {pe8, fe8}); end
        take8();
    endtask

    task automatic test_back_to_back();
        logic [6:0] g0, g1;
        send(2, {6'h3f, 2'b11, 7'h55, 1'b0}, 10);
        send(2, {6'h3f, 2'b11, 7'h2A, 1'b0}, 10);
        #BIT;
        @(negedge clk);
        g0 = (q7.size() > 0) ? q7[0] : 7'hxx;
        g1 = (q7.size() > 1) ? q7[1] : 7'hxx;
        checks++; if (q7.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", q7.size()); end
        checks++; if (g0 !== 7'h55) begin errors++; $display("FAIL b2b_first: got %h want 55", g0); end
        checks++; if (g1 !== 7'h2A) begin errors++; $display("FAIL b2b_second: got %h want 2a", g1); end
        checks++; if (fe7_cnt !== 0) begin errors++; $display("FAIL b2b_ferr: got %0d want 0", fe7_cnt); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_glitch();
        test_parity();
        test_break();
        test_overrun();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
